// File: rtl/outfifo_arbiter.sv
// outfifo_arbiter: round-robin return-path arbiter. Picks one thread whose
// output FIFO holds a complete packet, drains that packet word by word onto
// the shared output stream, then pulses a per-thread completion with the
// packet's word count. Packets are never interleaved on the output.
module outfifo_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int THREAD_BITS = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = 8,
    parameter int LEN_BITS    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_THREADS-1:0]            in_pkt_ready,
    input  logic [NUM_THREADS-1:0]            in_empty,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_THREADS*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_THREADS-1:0]            in_last,
    output logic [NUM_THREADS-1:0]            in_rd_en,
    input  logic                              out_rdy,
    output logic                              out_wr,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic [THREAD_BITS-1:0]            out_thread,
    output logic [NUM_THREADS-1:0]            pkt_sent,
    output logic [LEN_BITS-1:0]               pkt_words
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [THREAD_BITS-1:0] sel_q, sel_d;
    logic [THREAD_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [LEN_BITS-1:0]    word_cnt_q, word_cnt_d;

    logic                   out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]  out_ctrl_q, out_ctrl_d;
    logic [THREAD_BITS-1:0] out_thread_q, out_thread_d;

    // Head word of the selected thread's FIFO (first-word-fall-through).
    logic [DATA_WIDTH-1:0]  head_data;
    logic [CTRL_WIDTH-1:0]  head_ctrl;
    logic                   head_last;
    logic                   head_empty;
    logic                   rd_fire;

    logic                   grant_vld;
    logic [THREAD_BITS-1:0] grant_idx;
    logic [THREAD_BITS-1:0] cand;

    assign head_data  = in_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
    assign head_ctrl  = in_ctrl[int'(sel_q)*CTRL_WIDTH +: CTRL_WIDTH];
    assign head_last  = in_last[sel_q];
    assign head_empty = in_empty[sel_q];

    // A word is popped only while sending, downstream accepts and data exists.
    assign rd_fire = (state_q == SEND) && out_rdy && !head_empty;

    // Round-robin search: scan from the highest offset down so the requester
    // closest to rr_ptr is the one left standing.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = NUM_THREADS - 1; k >= 0; k--) begin
            cand = rr_ptr_q + THREAD_BITS'(k);
            if (in_pkt_ready[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pop strobe back to the selected thread FIFO: one-hot or zero.
    always_comb begin
        in_rd_en = '0;
        if (rd_fire) begin
            in_rd_en[sel_q] = 1'b1;
        end
    end

    // Next-state logic for the arbitration FSM and the output word register.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        word_cnt_d   = word_cnt_q;
        out_wr_d     = 1'b0;
        out_data_d   = out_data_q;
        out_ctrl_d   = out_ctrl_q;
        out_thread_d = out_thread_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    sel_d      = grant_idx;
                    word_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (rd_fire) begin
                    out_wr_d     = 1'b1;
                    out_data_d   = head_data;
                    out_ctrl_d   = head_ctrl;
                    out_thread_d = sel_q;
                    if (word_cnt_q != '1) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                    if (head_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rr_ptr_d = sel_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion pulse is decoded from DONE so reset silences it immediately.
    always_comb begin
        pkt_sent  = '0;
        pkt_words = '0;
        if (state_q == DONE) begin
            pkt_sent[sel_q] = 1'b1;
            pkt_words       = word_cnt_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Registered output stream; cleared on reset so nothing partial leaks out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr_q     <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_thread_q <= '0;
        end else begin
            out_wr_q     <= out_wr_d;
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
            out_thread_q <= out_thread_d;
        end
    end

    assign out_wr     = out_wr_q;
    assign out_data   = out_data_q;
    assign out_ctrl   = out_ctrl_q;
    assign out_thread = out_thread_q;

endmodule

// File: tb/tb_outfifo_arbiter.sv
// Testbench for outfifo_arbiter: models four thread FIFOs, drives directed
// packets and checks the output stream and completion pulses against a
// scoreboard of hand-ordered expected words.
module tb_outfifo_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   in_pkt_ready;
    logic [3:0]   in_empty;
    logic [255:0] in_data;
    logic [31:0]  in_ctrl;
    logic [3:0]   in_last;
    logic [3:0]   in_rd_en;
    logic         out_rdy;
    logic         out_wr;
    logic [63:0]  out_data;
    logic [7:0]   out_ctrl;
    logic [1:0]   out_thread;
    logic [3:0]   pkt_sent;
    logic [7:0]   pkt_words;

    outfifo_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .in_pkt_ready (in_pkt_ready),
        .in_empty     (in_empty),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_last      (in_last),
        .in_rd_en     (in_rd_en),
        .out_rdy      (out_rdy),
        .out_wr       (out_wr),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_thread   (out_thread),
        .pkt_sent     (pkt_sent),
        .pkt_words    (pkt_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Thread FIFO contents: {last, ctrl, data}.
    logic [72:0] fq [4][$];
    // Expected output words: {thread, ctrl, data}.
    logic [73:0] exp_q [$];
    // Expected completions: {pkt_sent one-hot, pkt_words}.
    logic [11:0] sent_q [$];
    logic [3:0]  stall;
    logic [3:0]  rd_s;
    int          vec;
    int          fails;

    function automatic logic [63:0] mkdata(int t, int p, int w);
        return {16'hD0A7, 8'(t), 8'(p), 16'h0, 8'(w), ~8'(w)};
    endfunction

    function automatic logic [7:0] mkctrl(int t, int w);
        return {4'(t), 4'(w)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        vec++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic refresh();
        logic [72:0] h;
        logic [72:0] e;
        logic        any;
        for (int i = 0; i < 4; i++) begin
            h = (fq[i].size() > 0) ? fq[i][0] : '0;
            in_empty[i] = (fq[i].size() == 0) || stall[i];
            in_data[i*64 +: 64] = h[63:0];
            in_ctrl[i*8 +: 8] = h[71:64];
            in_last[i] = h[72];
            any = 1'b0;
            for (int k = 0; k < fq[i].size(); k++) begin
                e = fq[i][k];
                if (e[72]) any = 1'b1;
            end
            in_pkt_ready[i] = any;
        end
    endtask

    // Advance one clock: pop whatever the DUT read at this edge, then
    // present the new FIFO heads. Returns 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rd_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic push_exp_word(int t, int p, int w);
        exp_q.push_back({2'(t), mkctrl(t, w), mkdata(t, p, w)});
    endtask

    task automatic push_pkt(int t, int p, int n, bit add_exp);
        for (int w = 1; w <= n; w++) begin
            fq[t].push_back({(w == n), mkctrl(t, w), mkdata(t, p, w)});
            if (add_exp) push_exp_word(t, p, w);
        end
        if (add_exp) sent_q.push_back({4'(1 << t), 8'(n)});
        refresh();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sent_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(exp_q.size() + sent_q.size()), 64'd0);
        tick();
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic monitor();
        logic [73:0] e;
        logic [11:0] s;
        forever begin
            @(negedge clk);
            rd_s = in_rd_en;
            if (!reset) begin
                if (out_wr) begin
                    vec++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL out_word: got t%0d %0h/%0h, required no word at %0t",
                                 out_thread, out_ctrl, out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_thread, out_ctrl, out_data} !== e) begin
                            fails++;
                            $display("FAIL out_word: got %0h, required %0h at %0t",
                                     {out_thread, out_ctrl, out_data}, e, $time);
                        end
                    end
                end
                if (pkt_sent != 4'b0) begin
                    vec++;
                    if (sent_q.size() == 0) begin
                        fails++;
                        $display("FAIL pkt_sent: got %b/%0d, required none at %0t",
                                 pkt_sent, pkt_words, $time);
                    end else begin
                        s = sent_q.pop_front();
                        if ({pkt_sent, pkt_words} !== s) begin
                            fails++;
                            $display("FAIL pkt_sent: got %b/%0d, required %b/%0d at %0t",
                                     pkt_sent, pkt_words, s[11:8], s[7:0], $time);
                        end
                    end
                end else begin
                    vec++;
                    if (pkt_words !== 8'd0) begin
                        fails++;
                        $display("FAIL pkt_words_idle: got %0d, required 0 at %0t", pkt_words, $time);
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset values
        @(negedge clk);
        chk("rst_out_wr", 64'(out_wr), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", 64'(out_ctrl), 0);
        chk("rst_out_thread", 64'(out_thread), 0);
        chk("rst_in_rd_en", 64'(in_rd_en), 0);
        chk("rst_pkt_sent", 64'(pkt_sent), 0);
        chk("rst_pkt_words", 64'(pkt_words), 0);
        tick();
        reset = 1'b0;
        tick();

        // Single 3-word packet on thread 2, exact cycle timing
        push_pkt(2, 1, 3, 1);
        tick();
        @(negedge clk);
        chk("t1_wr_after_grant", 64'(out_wr), 0);
        chk("t1_rd_en", 64'(in_rd_en), 64'b0100);
        tick();
        @(negedge clk);
        chk("t1_wr_w1", 64'(out_wr), 1);
        tick();
        @(negedge clk);
        chk("t1_wr_w2", 64'(out_wr), 1);
        tick();
        @(negedge clk);
        chk("t1_wr_w3", 64'(out_wr), 1);
        chk("t1_pkt_sent", 64'(pkt_sent), 64'b0100);
        chk("t1_pkt_words", 64'(pkt_words), 3);
        tick();
        @(negedge clk);
        chk("t1_wr_end", 64'(out_wr), 0);
        chk("t1_sent_end", 64'(pkt_sent), 0);
        wait_idle();

        // rr_ptr is now 3: threads 1 and 3 together -> 3 goes first
        push_pkt(3, 1, 2, 1);
        push_pkt(1, 1, 2, 1);
        wait_idle();

        // All four ready after reset -> 0,1,2,3; thread 0 re-raised mid-thread-1
        do_reset();
        push_pkt(0, 2, 2, 1);
        push_pkt(1, 2, 2, 1);
        push_pkt(2, 2, 2, 1);
        push_pkt(3, 2, 2, 1);
        repeat (6) tick();
        push_pkt(0, 3, 2, 1);
        wait_idle();

        // out_rdy pattern 1,0,0,... during a 5-word packet
        push_pkt(0, 4, 5, 1);
        for (int c = 0; c < 25; c++) begin
            out_rdy = (c % 3 == 0);
            @(negedge clk);
            if (!out_rdy) chk("rd_while_not_rdy", 64'(in_rd_en), 0);
            tick();
        end
        out_rdy = 1'b1;
        wait_idle();

        // Thread 1 FIFO empty for 3 cycles mid-packet
        push_pkt(1, 5, 4, 1);
        tick();
        tick();
        tick();
        stall[1] = 1'b1;
        refresh();
        @(negedge clk);
        chk("stall_rd0", 64'(in_rd_en), 0);
        tick();
        @(negedge clk);
        chk("stall_wr1", 64'(out_wr), 0);
        chk("stall_rd1", 64'(in_rd_en), 0);
        tick();
        @(negedge clk);
        chk("stall_wr2", 64'(out_wr), 0);
        chk("stall_rd2", 64'(in_rd_en), 0);
        tick();
        stall[1] = 1'b0;
        refresh();
        @(negedge clk);
        chk("stall_wr3", 64'(out_wr), 0);
        chk("stall_resume_rd", 64'(in_rd_en), 64'b0010);
        wait_idle();

        // Asynchronous reset on word 2 of a 4-word packet from thread 2
        push_pkt(2, 6, 4, 0);
        push_exp_word(2, 6, 1);
        tick();
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("arst_out_wr", 64'(out_wr), 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_ctrl", 64'(out_ctrl), 0);
        chk("arst_out_thread", 64'(out_thread), 0);
        chk("arst_in_rd_en", 64'(in_rd_en), 0);
        chk("arst_pkt_sent", 64'(pkt_sent), 0);
        push_pkt(0, 7, 2, 1);
        tick();
        tick();
        reset = 1'b0;
        push_exp_word(2, 6, 3);
        push_exp_word(2, 6, 4);
        sent_q.push_back({4'b0100, 8'd2});
        wait_idle();

        // 1-word packet on thread 3
        push_pkt(3, 8, 1, 1);
        tick();
        @(negedge clk);
        chk("one_rd_en", 64'(in_rd_en), 64'b1000);
        chk("one_wr_pre", 64'(out_wr), 0);
        chk("one_sent_pre", 64'(pkt_sent), 0);
        tick();
        @(negedge clk);
        chk("one_wr", 64'(out_wr), 1);
        chk("one_pkt_sent", 64'(pkt_sent), 64'b1000);
        chk("one_pkt_words", 64'(pkt_words), 1);
        tick();
        @(negedge clk);
        chk("one_wr_post", 64'(out_wr), 0);
        chk("one_sent_post", 64'(pkt_sent), 0);
        chk("one_rd_post", 64'(in_rd_en), 0);
        wait_idle();
    endtask

    initial begin
        vec     = 0;
        fails   = 0;
        reset   = 1'b1;
        out_rdy = 1'b1;
        stall   = 4'b0;
        rd_s    = 4'b0;
        in_pkt_ready = '0;
        in_empty = '1;
        in_data  = '0;
        in_ctrl  = '0;
        in_last  = '0;
        refresh();
        tick();
        fork
            monitor();
            begin
                stimulus();
                $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
                $finish;
            end
        join_any
    end

endmodule

// File: doc/outfifo_arbiter.md
# outfifo_arbiter

Return-path arbiter for the multithreaded packet processor. Each hardware thread places completed packets in its own output FIFO. This block selects one ready thread at a time in round-robin order and drains that thread's packet, word by word, onto the single shared output stream toward the MAC/output queues. Packets are never interleaved. When a packet's last word has been written, the block pulses a per-thread completion back so the thread can release its buffer.

## Interface
- NUM_THREADS, 4, number of thread output FIFOs (design fixed at 4)
- THREAD_BITS, 2, width of thread index
- DATA_WIDTH, 64, packet word width
- CTRL_WIDTH, 8, control word width per data word
- LEN_BITS, 8, width of packet word counter

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_pkt_ready  input  NUM_THREADS  thread i holds at least one complete packet
- in_empty  input  NUM_THREADS  thread i FIFO empty (first-word-fall-through)
- in_data  input  NUM_THREADS*DATA_WIDTH  packed head words; thread i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_ctrl  input  NUM_THREADS*CTRL_WIDTH  packed head ctrl, same packing
- in_last  input  NUM_THREADS  head word of thread i is the packet's last word
- in_rd_en  output  NUM_THREADS  pop head of thread i FIFO (combinational, one-hot or zero)
- out_rdy  input  1  downstream can accept a word this cycle
- out_wr  output  1  out_data/out_ctrl valid (registered)
- out_data  output  DATA_WIDTH  registered output word
- out_ctrl  output  CTRL_WIDTH  registered output ctrl
- out_thread  output  THREAD_BITS  source thread of the word on out_data (registered)
- pkt_sent  output  NUM_THREADS  one-cycle pulse, packet from thread i fully written
- pkt_words  output  LEN_BITS  word count of the packet, valid with pkt_sent

## Operation
- States: IDLE, SEND, DONE. Reset state is IDLE.
- Registers: sel (THREAD_BITS), rr_ptr (THREAD_BITS), word_cnt (LEN_BITS).
- IDLE behaviour:
  - Grant the first thread j with in_pkt_ready[j]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_THREADS.
  - On grant: sel<=j, word_cnt<=0, go to SEND.
  - With no requester, stay in IDLE.
- SEND read rule: in_rd_en[sel] = out_rdy & ~in_empty[sel]. All other in_rd_en bits are 0.
- SEND on each read:
  - out_data/out_ctrl/out_thread <= head of sel; out_wr<=1.
  - word_cnt <= word_cnt+1, saturating at all-ones.
  - If in_last[sel]=1 on the read, go to DONE.
- SEND with no read (out_rdy=0 or in_empty[sel]=1): out_wr<=0 and the state holds. A stall of any length never drops or duplicates a word.
- DONE: pkt_sent[sel]=1 and pkt_words=word_cnt for exactly one cycle. rr_ptr<=sel+1 (wraps 3→0). Go to IDLE.
- Outside DONE, pkt_sent=0 and pkt_words=0.
- in_pkt_ready is sampled only in IDLE. Changes during SEND or DONE are ignored.
- Reset mid-packet:
  - All outputs go to 0 immediately (asynchronous); state=IDLE, rr_ptr=0.
  - No pkt_sent is issued for the partial packet. The unread remainder stays in the thread FIFO.
- Packet boundary on the output: first out_wr after a grant is the first word; the word read with in_last is the final word.

## Timing
- Reset values: in_rd_en=0, out_wr=0, out_data=0, out_ctrl=0, out_thread=0, pkt_sent=0, pkt_words=0.
- Grant latency: in_pkt_ready sampled high in IDLE at cycle N → SEND at N+1. in_rd_en can assert at N+1 and out_wr at N+2.
- Read-to-output latency: 1 cycle (out_wr registered from in_rd_en).
- Throughput: 1 word/cycle while out_rdy=1 and the FIFO is non-empty.
- Last word read at cycle M → final out_wr at M+1, DONE at M+1 (pkt_sent pulse), IDLE at M+2, next grant decision at M+2. Back-to-back packets therefore incur 2 idle output cycles.
- out_rdy is consumed combinationally in the same cycle it is presented. Downstream must tolerate one write in the cycle after deasserting out_rdy.

## Test plan
- Single packet, thread 2, 3 words (last on word 3), out_rdy=1 → out_wr at cycles N+2..N+4 with out_thread=2, words in order; pkt_sent=4'b0100 and pkt_words=3 at N+4; rr_ptr=3.
- All four threads ready at once after reset → packets drained in order 0,1,2,3, never interleaved. Re-raising thread 0 during thread 1's packet is served only after 2 and 3.
- out_rdy toggled 1,0,0,1,… during a 5-word packet → no in_rd_en while out_rdy=0; exactly 5 out_wr with correct data; pkt_words=5.
- in_empty[sel] high for 3 cycles mid-packet → out_wr low for those cycles, no duplicate word, packet completes normally.
- reset asserted asynchronously on word 2 of a 4-word packet → all outputs 0 without waiting for a clock edge; no pkt_sent; after release, a ready thread 0 is granted first.
- 1-word packet (in_last on the first word) → single out_wr, pkt_words=1, pkt_sent one cycle later than the word read, IDLE the following cycle.
